mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; clears state register and flags register.
REQ-003 SHALL have port Cond, input, 4: Instr[31:28], condition field.
REQ-004 SHALL have port Op, input, 2: Instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 SHALL have port Funct, input, 6: Instr[25:20]; [5] I, [4:1] cmd, [0] S/L; [3] U for memory.
REQ-006 SHALL have port Rd, input, 4: Instr[15:12].
REQ-007 SHALL have port ALUFlags, input, 4: {N,Z,C,V} from the datapath ALU.
REQ-008 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, each 1 bit: datapath enables and mux selects.
REQ-009 SHALL have outputs ALUSrcB (2), ResultSrc (2), ImmSrc (2), RegSrc (2), ALUControl (4): datapath selects.
REQ-010 SHALL have output PrevC, 1 bit: stored C flag fed back to the ALU for carry/shift operations.
REQ-011 SHALL have output State, 4 bits: current state, for debug and the bench.

Function
REQ-012 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH; every other encoding SHALL go to FETCH.
REQ-013 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECI (Op=00,I=1), EXECR (Op=00,I=0), BRANCH (Op=10), FETCH (Op=11); MEMADR->MEMRD (L=1) or MEMWR (L=0); MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-014 Latency SHALL be: LDR 5 cycles, STR 4, data-processing 4, B 3, undefined 2.
REQ-015 In FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
REQ-016 In DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; RegSrc and ImmSrc decoded from Op; no enables asserted.
REQ-017 ImmSrc SHALL be Op; RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
REQ-018 MEMADR SHALL select ALUSrcA=0, ALUSrcB=01, ALUControl=ADD if U=1, else SUB.
REQ-019 MEMRD and MEMWR SHALL set AdrSrc=1; MemWrite=CondEx in MEMWR only.
REQ-020 MEMWB SHALL set ResultSrc=01, RegWrite=CondEx and not PCS, PCWrite=CondEx and PCS.
REQ-021 EXECR/EXECI SHALL set ALUSrcA=0, ALUSrcB=00/01, ALUControl=cmd.
REQ-022 ALUWB SHALL set ResultSrc=00; RegWrite=CondEx and not PCS and not (cmd in CMP/CMN/TST/TEQ); PCWrite=CondEx and PCS.
REQ-023 BRANCH SHALL set ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx.
REQ-024 PCS SHALL be (Rd==15) for LDR or data-processing writes.
REQ-025 CondEx SHALL be evaluated combinationally from Cond and the flags register: EQ..LE per ARM, AL=1, NV (1111)=0.
REQ-026 Flags register SHALL load ALUFlags at end of EXECR/EXECI only when S=1 and CondEx=1; otherwise hold.
REQ-027 PrevC SHALL equal flags register C bit.
REQ-028 CondEx=0 SHALL not alter state sequence; only write enables are suppressed.
REQ-029 All outputs in unlisted states SHALL be 0.

Reset
REQ-030 Reset SHALL force State=FETCH and flags=0000 immediately, independent of clk.
REQ-031 On reset deassertion, the first rising edge SHALL perform FETCH outputs, then advance to DECODE.
REQ-032 Reset mid-instruction SHALL abort it with no further write enables asserted.

Structure
REQ-033 State enum, ALU command constants (ADD, SUB, AND, ORR, EOR, MOV, CMP, TST, ...) and condition codes SHALL reside in a shared package mc_pkg.
REQ-034 Condition evaluation SHALL be the sub-module cond_check (Cond, Flags -> CondEx).

Verification
REQ-035 Reset during MEMRD -> State=FETCH at once, flags=0000, RegWrite=0.
REQ-036 ADD R1,R2,#5 (Cond=1110, Op=00, Funct=101000) -> FETCH, DECODE, EXECI, ALUWB; RegWrite=1 only in ALUWB; ALUControl=0100.
REQ-037 SUBS with ALUFlags=0100, then BEQ -> flags=0100; BRANCH asserts PCWrite=1; BNE with same flags -> PCWrite=0, 3 cycles.
REQ-038 LDR R15,[R0,#4] -> 5 cycles; MEMWB asserts PCWrite=1, RegWrite=0.
REQ-039 STR with Cond=1111 -> 4 cycles, MemWrite=0 in MEMWR.
REQ-040 Op=11 -> DECODE->FETCH, no enable asserted beyond FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle ARM-style control unit.
// States, ALU commands, condition codes and the control-word payload.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 4;

  // Flag bit positions inside {N,Z,C,V}
  localparam int unsigned FLAG_C = 1;

  localparam logic [OP_W-1:0] OP_DP  = 2'b00;
  localparam logic [OP_W-1:0] OP_MEM = 2'b01;
  localparam logic [OP_W-1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  typedef enum logic [CMD_W-1:0] {
    ALU_AND = 4'b0000, ALU_EOR = 4'b0001, ALU_SUB = 4'b0010, ALU_RSB = 4'b0011,
    ALU_ADD = 4'b0100, ALU_ADC = 4'b0101, ALU_SBC = 4'b0110, ALU_RSC = 4'b0111,
    ALU_TST = 4'b1000, ALU_TEQ = 4'b1001, ALU_CMP = 4'b1010, ALU_CMN = 4'b1011,
    ALU_ORR = 4'b1100, ALU_MOV = 4'b1101, ALU_BIC = 4'b1110, ALU_MVN = 4'b1111
  } alu_cmd_e;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_write;
    logic             adr_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       result_src;
    logic [CMD_W-1:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_if.sv
// Instruction fields and ALU flags in, datapath enables/selects out.
// The master side is the datapath (or bench); the slave side is the controller.
interface mc_controller_if;
  import mc_pkg::*;

  logic [COND_W-1:0]  Cond;
  logic [OP_W-1:0]    Op;
  logic [FUNCT_W-1:0] Funct;
  logic [REG_W-1:0]   Rd;
  logic [FLAGS_W-1:0] ALUFlags;

  logic               PCWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               MemWrite;
  logic               AdrSrc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic [1:0]         ImmSrc;
  logic [1:0]         RegSrc;
  logic [CMD_W-1:0]   ALUControl;
  logic               PrevC;
  logic [STATE_W-1:0] State;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, PrevC, State
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, PrevC, State
  );
endinterface

// File: rtl/cond_check.sv
// ARM condition-field evaluation against the stored {N,Z,C,V} flags.
module cond_check
  import mc_pkg::*;
(
  input  logic [COND_W-1:0]  Cond,
  input  logic [FLAGS_W-1:0] Flags,
  output logic               CondEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = Flags;

  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ~(n ^ v);
      COND_LT: CondEx = n ^ v;
      COND_GT: CondEx = ~z & ~(n ^ v);
      COND_LE: CondEx = z | (n ^ v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore control FSM with a conditionally-updated flags register.
// Outputs decode from the current state; only write enables depend on CondEx.
module mc_controller
  import mc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.slave  bus
);

  state_e              state_q, state_d;
  logic [FLAGS_W-1:0]  flags_q, flags_d;
  ctrl_t               ctrl_c;
  logic                cond_ex;
  logic [CMD_W-1:0]    cmd;
  logic                is_imm, is_load, is_up, set_flags, no_write, rd_pc;

  assign cmd       = bus.Funct[4:1];
  assign is_imm    = bus.Funct[5];
  assign is_up     = bus.Funct[3];
  assign is_load   = bus.Funct[0];
  assign set_flags = bus.Funct[0];
  // TST/TEQ/CMP/CMN share the 10xx command pattern and never write Rd
  assign no_write  = (cmd[3:2] == 2'b10);
  assign rd_pc     = (bus.Rd == REG_W'(15));

  cond_check u_cond_check (
    .Cond   (bus.Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign flags_d = ((state_q == S_EXECR || state_q == S_EXECI) && set_flags && cond_ex)
                   ? bus.ALUFlags : flags_q;

  // Next state and per-state control word
  always_comb begin
    state_d = S_FETCH;
    ctrl_c  = '0;
    case (state_q)
      S_FETCH: begin
        state_d            = S_DECODE;
        ctrl_c.ir_write    = 1'b1;
        ctrl_c.pc_write    = 1'b1;
        ctrl_c.alu_src_a   = 1'b1;
        ctrl_c.alu_src_b   = SRCB_FOUR;
        ctrl_c.alu_control = ALU_ADD;
        ctrl_c.result_src  = RES_ALU;
      end
      S_DECODE: begin
        ctrl_c.alu_src_a   = 1'b1;
        ctrl_c.alu_src_b   = SRCB_FOUR;
        ctrl_c.alu_control = ALU_ADD;
        ctrl_c.result_src  = RES_ALU;
        case (bus.Op)
          OP_DP:   state_d = is_imm ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d            = is_load ? S_MEMRD : S_MEMWR;
        ctrl_c.alu_src_b   = SRCB_IMM;
        ctrl_c.alu_control = is_up ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: begin
        state_d        = S_MEMWB;
        ctrl_c.adr_src = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.adr_src   = 1'b1;
        ctrl_c.mem_write = cond_ex;
      end
      S_MEMWB: begin
        ctrl_c.result_src = RES_DATA;
        ctrl_c.reg_write  = cond_ex & ~rd_pc;
        ctrl_c.pc_write   = cond_ex & rd_pc;
      end
      S_EXECR: begin
        state_d            = S_ALUWB;
        ctrl_c.alu_src_b   = SRCB_REG;
        ctrl_c.alu_control = cmd;
      end
      S_EXECI: begin
        state_d            = S_ALUWB;
        ctrl_c.alu_src_b   = SRCB_IMM;
        ctrl_c.alu_control = cmd;
      end
      S_ALUWB: begin
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.reg_write  = cond_ex & ~rd_pc & ~no_write;
        ctrl_c.pc_write   = cond_ex & rd_pc & ~no_write;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_b   = SRCB_IMM;
        ctrl_c.alu_control = ALU_ADD;
        ctrl_c.result_src  = RES_ALU;
        ctrl_c.pc_write    = cond_ex;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.PCWrite    = ctrl_c.pc_write;
  assign bus.IRWrite    = ctrl_c.ir_write;
  assign bus.RegWrite   = ctrl_c.reg_write;
  assign bus.MemWrite   = ctrl_c.mem_write;
  assign bus.AdrSrc     = ctrl_c.adr_src;
  assign bus.ALUSrcA    = ctrl_c.alu_src_a;
  assign bus.ALUSrcB    = ctrl_c.alu_src_b;
  assign bus.ResultSrc  = ctrl_c.result_src;
  assign bus.ALUControl = ctrl_c.alu_control;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
  assign bus.PrevC      = flags_q[FLAG_C];
  assign bus.State      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench: directed instruction cases plus random instructions
// compared cycle by cycle against an instruction-level reference model.
module tb_mc_controller;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [3:0]  m_flags;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Predicate for the condition field: pairs share a base test, odd codes invert it
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  // Run one instruction from its FETCH cycle; called just after a rising edge in FETCH
  task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] exec_flags);
    state_e     seq[$];
    logic       ok, is_cmp, pc_dest, upd;
    logic [3:0] e_en;
    logic [3:0] e_alu;
    logic [1:0] e_srcb, e_res;
    logic       e_adr, e_srca;
    bus.Cond = c; bus.Op = op; bus.Funct = fn; bus.Rd = rd;
    seq = {S_FETCH, S_DECODE};
    case (op)
      2'b00: begin seq.push_back(fn[5] ? S_EXECI : S_EXECR); seq.push_back(S_ALUWB); end
      2'b01: begin
        seq.push_back(S_MEMADR);
        if (fn[0]) begin seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
        else seq.push_back(S_MEMWR);
      end
      2'b10: seq.push_back(S_BRANCH);
      default: ;
    endcase
    is_cmp  = (fn[4:1] >= 4'd8) && (fn[4:1] <= 4'd11);
    pc_dest = (rd == 4'd15) && !is_cmp;
    foreach (seq[k]) begin
      upd = 1'b0;
      bus.ALUFlags = (seq[k] == S_EXECR || seq[k] == S_EXECI) ? exec_flags : 4'($urandom);
      @(negedge clk);
      ok = cond_holds(c, m_flags);
      e_en = 4'b0000; e_adr = 1'b0; e_srca = 1'b0; e_srcb = 2'd0; e_res = 2'd0; e_alu = 4'd0;
      case (seq[k])
        S_FETCH:  begin e_en = 4'b1100; e_srca = 1'b1; e_srcb = 2'd2; e_res = 2'd2; e_alu = 4'b0100; end
        S_DECODE: begin e_srca = 1'b1; e_srcb = 2'd2; e_res = 2'd2; e_alu = 4'b0100; end
        S_MEMADR: begin e_srcb = 2'd1; e_alu = fn[3] ? 4'b0100 : 4'b0010; end
        S_MEMRD:  e_adr = 1'b1;
        S_MEMWR:  begin e_adr = 1'b1; e_en = {3'b000, ok}; end
        S_MEMWB:  begin e_res = 2'd1; e_en = {ok && rd == 4'd15, 1'b0, ok && rd != 4'd15, 1'b0}; end
        S_EXECR:  begin e_alu = fn[4:1]; upd = fn[0] && ok; end
        S_EXECI:  begin e_srcb = 2'd1; e_alu = fn[4:1]; upd = fn[0] && ok; end
        S_ALUWB:  e_en = {ok && pc_dest, 1'b0, ok && !pc_dest && !is_cmp, 1'b0};
        S_BRANCH: begin e_srcb = 2'd1; e_res = 2'd2; e_alu = 4'b0100; e_en = {ok, 3'b000}; end
        default: ;
      endcase
      check_eq($sformatf("%s.c%0d.state", name, k), 32'(bus.State), 32'(seq[k]));
      check_eq($sformatf("%s.c%0d.en{pc,ir,reg,mem}", name, k),
               32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}), 32'(e_en));
      check_eq($sformatf("%s.c%0d.sel{adr,a,b,res,alu}", name, k),
               32'({bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl}),
               32'({e_adr, e_srca, e_srcb, e_res, e_alu}));
      check_eq($sformatf("%s.c%0d.imm_reg_src", name, k), 32'({bus.ImmSrc, bus.RegSrc}),
               32'({op, op == 2'b01, op == 2'b10}));
      check_eq($sformatf("%s.c%0d.prevc", name, k), 32'(bus.PrevC), 32'(m_flags[1]));
      @(posedge clk); #1;
      if (upd) m_flags = exec_flags;
    end
  endtask

  task automatic reset_in_memrd();
    bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'd3;
    bus.ALUFlags = 4'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.pre_state", 32'(bus.State), 32'(S_MEMRD));
    #2 reset = 1'b1;
    #1;
    m_flags = 4'b0000;
    check_eq("rst.async_state", 32'(bus.State), 32'(S_FETCH));
    check_eq("rst.async_prevc", 32'(bus.PrevC), 32'(0));
    check_eq("rst.async_regwrite", 32'({bus.RegWrite, bus.MemWrite}), 32'(0));
    @(posedge clk); #1;
    check_eq("rst.held_state", 32'(bus.State), 32'(S_FETCH));
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.Cond = 4'h0; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
    m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.state", 32'(bus.State), 32'(S_FETCH));
    check_eq("reset.prevc", 32'(bus.PrevC), 32'(0));
    reset = 1'b0;

    run_instr("add_imm",  4'hE, 2'b00, 6'b101000, 4'd1,  4'b1111);
    run_instr("subs",     4'hE, 2'b00, 6'b000101, 4'd3,  4'b0100);
    run_instr("beq",      4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000);
    run_instr("bne",      4'h1, 2'b10, 6'b100000, 4'd0,  4'b0000);
    run_instr("ldr_pc",   4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);
    run_instr("str_nv",   4'hF, 2'b01, 6'b011000, 4'd2,  4'b0000);
    run_instr("undef",    4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000);
    run_instr("cmp_nz",   4'hE, 2'b00, 6'b110101, 4'd0,  4'b0011);
    run_instr("adds_c",   4'hE, 2'b00, 6'b101001, 4'd4,  4'b0010);
    run_instr("movne_pc", 4'h1, 2'b00, 6'b111010, 4'd15, 4'b0000);
    reset_in_memrd();
    run_instr("after_rst", 4'hE, 2'b00, 6'b000100, 4'd5, 4'b0000);

    for (int i = 0; i < 200; i++) begin
      logic [3:0] c, rd, fl;
      c  = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      fl = 4'($urandom);
      run_instr($sformatf("rnd%0d", i), c, 2'($urandom), 6'($urandom), rd, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
